// File: rtl/rename_nway.sv
// Superscalar register rename: map table, circular free list, ROB tag allocator and
// branch checkpoints. Each cycle renames a contiguous lane prefix ending at the first branch.

module rename_nway_lane #(
  parameter int LANE       = 0,
  parameter int WIDTH      = 2,
  parameter int AREG_WIDTH = 5,
  parameter int PREG_WIDTH = 7
) (
  input  logic [AREG_WIDTH-1:0]            rs1,
  input  logic [AREG_WIDTH-1:0]            rs2,
  input  logic [AREG_WIDTH-1:0]            rd,
  input  logic [PREG_WIDTH-1:0]            map_rs1,
  input  logic [PREG_WIDTH-1:0]            map_rs2,
  input  logic [PREG_WIDTH-1:0]            map_rd,
  input  logic [WIDTH-1:0][AREG_WIDTH-1:0] grp_rd,
  input  logic [WIDTH-1:0][PREG_WIDTH-1:0] grp_prd,
  input  logic [WIDTH-1:0]                 grp_wr,
  output logic [PREG_WIDTH-1:0]            prs1,
  output logic [PREG_WIDTH-1:0]            prs2,
  output logic [PREG_WIDTH-1:0]            old_prd
);
  always_comb begin
    prs1    = map_rs1;
    prs2    = map_rs2;
    old_prd = map_rd;
    // Oldest to youngest, so the youngest older writer in the group wins.
    for (int i = 0; i < WIDTH; i++) begin
      if (i < LANE && grp_wr[i]) begin
        if (grp_rd[i] == rs1) prs1    = grp_prd[i];
        if (grp_rd[i] == rs2) prs2    = grp_prd[i];
        if (grp_rd[i] == rd)  old_prd = grp_prd[i];
      end
    end
  end
endmodule

module rename_nway #(
  parameter int  AREG_WIDTH = 5,
  parameter int  PREG_WIDTH = 7,
  parameter int  ROB_WIDTH  = 4,
  parameter int  WIDTH      = 2,
  parameter int  NUM_CKPT   = 4,
  localparam int CKPT_W     = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            decode_valid,
  input  logic [WIDTH*AREG_WIDTH-1:0] decode_rs1,
  input  logic [WIDTH*AREG_WIDTH-1:0] decode_rs2,
  input  logic [WIDTH*AREG_WIDTH-1:0] decode_rd,
  input  logic [WIDTH-1:0]            decode_is_branch,
  input  logic [WIDTH-1:0]            decode_reg_write,
  input  logic                        i_ready,
  output logic                        rename_ready,
  output logic [WIDTH-1:0]            rename_accept,
  output logic [WIDTH-1:0]            dispatch_valid,
  output logic [WIDTH*PREG_WIDTH-1:0] dispatch_prs1,
  output logic [WIDTH*PREG_WIDTH-1:0] dispatch_prs2,
  output logic [WIDTH*PREG_WIDTH-1:0] dispatch_prd,
  output logic [WIDTH*PREG_WIDTH-1:0] dispatch_old_prd,
  output logic [WIDTH*ROB_WIDTH-1:0]  dispatch_rob_tag,
  output logic [WIDTH-1:0]            dispatch_reg_write,
  output logic [CKPT_W-1:0]           dispatch_ckpt_id,
  output logic [NUM_CKPT-1:0]         dispatch_br_mask,
  input  logic [WIDTH-1:0]            commit_en,
  input  logic [WIDTH*PREG_WIDTH-1:0] commit_old_preg,
  input  logic                        branch_resolve,
  input  logic                        branch_mispredict,
  input  logic [CKPT_W-1:0]           branch_ckpt_id
);
  localparam int NAREG = 1 << AREG_WIDTH;
  localparam int NPREG = 1 << PREG_WIDTH;

  logic [WIDTH-1:0][AREG_WIDTH-1:0] rs1, rs2, rd;
  logic [WIDTH-1:0][PREG_WIDTH-1:0] cold, prd;
  assign rs1  = decode_rs1;
  assign rs2  = decode_rs2;
  assign rd   = decode_rd;
  assign cold = commit_old_preg;

  logic [NAREG-1:0][PREG_WIDTH-1:0] map_q, map_grp;
  logic [NPREG-1:0][PREG_WIDTH-1:0] fl_q;
  logic [PREG_WIDTH:0]              fl_head, fl_tail, fl_count, tail_n, nwr;
  logic [ROB_WIDTH-1:0]             rob_tail, nacc;
  logic [NUM_CKPT-1:0]              ck_vld, vld_n;
  logic [NUM_CKPT-1:0][NUM_CKPT-1:0] ck_older, older_n;
  logic [NUM_CKPT-1:0][NAREG-1:0][PREG_WIDTH-1:0] ck_map;
  logic [NUM_CKPT-1:0][PREG_WIDTH:0]    ck_head;
  logic [NUM_CKPT-1:0][ROB_WIDTH-1:0]   ck_rob;
  logic [WIDTH-1:0]                     wr, prefix, push_en;
  logic [WIDTH-1:0][PREG_WIDTH-1:0]     push_idx;
  logic [CKPT_W-1:0]                    alloc_id;
  logic                                 has_br, ck_free, res_ok, mp_now, br_new;

  assign fl_count = fl_tail - fl_head;
  assign res_ok   = branch_resolve & ck_vld[branch_ckpt_id];
  assign mp_now   = res_ok & branch_mispredict;
  assign ck_free  = ~&ck_vld;

  // Prefix runs from lane 0 up to and including the first branch lane.
  always_comb begin
    prefix = '0;
    has_br = 1'b0;
    nacc   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      wr[i] = decode_valid[i] & decode_reg_write[i] & (rd[i] != '0);
      if (!has_br && decode_valid[i]) begin
        prefix[i] = 1'b1;
        nacc      = nacc + ROB_WIDTH'(1);
        if (decode_is_branch[i]) has_br = 1'b1;
      end
    end
  end

  always_comb begin
    nwr = '0;
    for (int i = 0; i < WIDTH; i++) begin
      prd[i] = '0;
      if (wr[i]) prd[i] = fl_q[fl_head[PREG_WIDTH-1:0] + nwr[PREG_WIDTH-1:0]];
      if (wr[i] && prefix[i]) nwr = nwr + (PREG_WIDTH+1)'(1);
    end
  end

  assign rename_ready = !reset & i_ready & !mp_now & (fl_count >= nwr) & (!has_br | ck_free);
  assign br_new       = rename_ready & has_br;

  always_comb begin
    alloc_id = '0;
    for (int j = NUM_CKPT-1; j >= 0; j--)
      if (!ck_vld[j]) alloc_id = CKPT_W'(j);
  end

  always_comb begin
    map_grp = map_q;
    for (int i = 0; i < WIDTH; i++)
      if (rename_ready && prefix[i] && wr[i]) map_grp[rd[i]] = prd[i];
  end

  always_comb begin
    tail_n = fl_tail;
    for (int i = 0; i < WIDTH; i++) begin
      push_en[i]  = commit_en[i] && (cold[i] != '0);
      push_idx[i] = tail_n[PREG_WIDTH-1:0];
      if (push_en[i]) tail_n = tail_n + (PREG_WIDTH+1)'(1);
    end
  end

  // A mispredict kills its checkpoint and every younger one that recorded it as older.
  always_comb begin
    vld_n   = ck_vld;
    older_n = ck_older;
    if (res_ok) begin
      if (branch_mispredict) begin
        for (int j = 0; j < NUM_CKPT; j++)
          if (CKPT_W'(j) == branch_ckpt_id || ck_older[j][branch_ckpt_id]) vld_n[j] = 1'b0;
      end else begin
        vld_n[branch_ckpt_id] = 1'b0;
        for (int j = 0; j < NUM_CKPT; j++) older_n[j][branch_ckpt_id] = 1'b0;
      end
    end
    if (br_new) begin
      older_n[alloc_id] = vld_n;
      vld_n[alloc_id]   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < NAREG; a++) map_q[a] <= PREG_WIDTH'(a);
      for (int e = 0; e < NPREG; e++)
        fl_q[e] <= (e < NPREG - NAREG) ? PREG_WIDTH'(e + NAREG) : '0;
      fl_head  <= '0;
      fl_tail  <= (PREG_WIDTH+1)'(NPREG - NAREG);
      rob_tail <= '0;
      ck_vld   <= '0;
      ck_older <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (push_en[i]) fl_q[push_idx[i]] <= cold[i];
      fl_tail  <= tail_n;
      ck_vld   <= vld_n;
      ck_older <= older_n;
      if (mp_now) begin
        map_q    <= ck_map[branch_ckpt_id];
        fl_head  <= ck_head[branch_ckpt_id];
        rob_tail <= ck_rob[branch_ckpt_id];
      end else begin
        map_q <= map_grp;
        if (rename_ready) begin
          fl_head  <= fl_head + nwr;
          rob_tail <= rob_tail + nacc;
        end
      end
      if (br_new) begin
        ck_map[alloc_id]  <= map_grp;
        ck_head[alloc_id] <= fl_head + nwr;
        ck_rob[alloc_id]  <= rob_tail + nacc;
      end
    end
  end

  assign rename_accept      = rename_ready ? prefix : '0;
  assign dispatch_valid     = rename_accept;
  assign dispatch_reg_write = reset ? '0 : wr;
  assign dispatch_ckpt_id   = br_new ? alloc_id : '0;
  assign dispatch_br_mask   = rename_ready ? ck_vld : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [PREG_WIDTH-1:0] l_prs1, l_prs2, l_old;
    rename_nway_lane #(
      .LANE(i), .WIDTH(WIDTH), .AREG_WIDTH(AREG_WIDTH), .PREG_WIDTH(PREG_WIDTH)
    ) u_lane (
      .rs1(rs1[i]), .rs2(rs2[i]), .rd(rd[i]),
      .map_rs1(map_q[rs1[i]]), .map_rs2(map_q[rs2[i]]), .map_rd(map_q[rd[i]]),
      .grp_rd(rd), .grp_prd(prd), .grp_wr(wr),
      .prs1(l_prs1), .prs2(l_prs2), .old_prd(l_old)
    );
    assign dispatch_prs1[i*PREG_WIDTH +: PREG_WIDTH]    = reset ? '0 : l_prs1;
    assign dispatch_prs2[i*PREG_WIDTH +: PREG_WIDTH]    = reset ? '0 : l_prs2;
    assign dispatch_old_prd[i*PREG_WIDTH +: PREG_WIDTH] = reset ? '0 : l_old;
    assign dispatch_prd[i*PREG_WIDTH +: PREG_WIDTH]     = reset ? '0 : prd[i];
    assign dispatch_rob_tag[i*ROB_WIDTH +: ROB_WIDTH]   = reset ? '0 : rob_tail + ROB_WIDTH'(i);
  end
endmodule

// File: tb/tb_rename_nway.sv
// Directed bench for rename_nway: bypass, branch split, checkpoint recovery, free-list exhaustion.

module tb_rename_nway;
  localparam int AW = 5, PW = 7, RW = 4, W = 2, NC = 4, CW = 2;

  logic            clk, reset, i_ready, rename_ready;
  logic [W-1:0]    decode_valid, decode_is_branch, decode_reg_write;
  logic [W*AW-1:0] decode_rs1, decode_rs2, decode_rd;
  logic [W-1:0]    rename_accept, dispatch_valid, dispatch_reg_write, commit_en;
  logic [W*PW-1:0] dispatch_prs1, dispatch_prs2, dispatch_prd, dispatch_old_prd, commit_old_preg;
  logic [W*RW-1:0] dispatch_rob_tag;
  logic [CW-1:0]   dispatch_ckpt_id, branch_ckpt_id;
  logic [NC-1:0]   dispatch_br_mask;
  logic            branch_resolve, branch_mispredict;
  int              nvec, nerr;

  rename_nway #(.AREG_WIDTH(AW), .PREG_WIDTH(PW), .ROB_WIDTH(RW), .WIDTH(W), .NUM_CKPT(NC)) dut (
    .clk(clk), .reset(reset), .decode_valid(decode_valid),
    .decode_rs1(decode_rs1), .decode_rs2(decode_rs2), .decode_rd(decode_rd),
    .decode_is_branch(decode_is_branch), .decode_reg_write(decode_reg_write),
    .i_ready(i_ready), .rename_ready(rename_ready), .rename_accept(rename_accept),
    .dispatch_valid(dispatch_valid), .dispatch_prs1(dispatch_prs1), .dispatch_prs2(dispatch_prs2),
    .dispatch_prd(dispatch_prd), .dispatch_old_prd(dispatch_old_prd),
    .dispatch_rob_tag(dispatch_rob_tag), .dispatch_reg_write(dispatch_reg_write),
    .dispatch_ckpt_id(dispatch_ckpt_id), .dispatch_br_mask(dispatch_br_mask),
    .commit_en(commit_en), .commit_old_preg(commit_old_preg),
    .branch_resolve(branch_resolve), .branch_mispredict(branch_mispredict),
    .branch_ckpt_id(branch_ckpt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] g_prs1(input int l); return dispatch_prs1[l*PW +: PW]; endfunction
  function automatic logic [PW-1:0] g_prs2(input int l); return dispatch_prs2[l*PW +: PW]; endfunction
  function automatic logic [PW-1:0] g_prd(input int l);  return dispatch_prd[l*PW +: PW]; endfunction
  function automatic logic [PW-1:0] g_old(input int l);  return dispatch_old_prd[l*PW +: PW]; endfunction
  function automatic logic [RW-1:0] g_tag(input int l);  return dispatch_rob_tag[l*RW +: RW]; endfunction

  task automatic idle();
    decode_valid = '0; decode_is_branch = '0; decode_reg_write = '0;
    decode_rs1 = '0; decode_rs2 = '0; decode_rd = '0;
    i_ready = 1'b1; commit_en = '0; commit_old_preg = '0;
    branch_resolve = 1'b0; branch_mispredict = 1'b0; branch_ckpt_id = '0;
  endtask

  task automatic set_lane(input int l, input logic v, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                          input logic [AW-1:0] d, input logic br, input logic rw);
    decode_valid[l] = v; decode_is_branch[l] = br; decode_reg_write[l] = rw;
    decode_rs1[l*AW +: AW] = s1; decode_rs2[l*AW +: AW] = s2; decode_rd[l*AW +: AW] = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_lane(0, 1, 3, 3, 1, 0, 1); set_lane(1, 1, 3, 3, 2, 0, 1); #1;
    nvec++; if (rename_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready got %0d want 0", rename_ready); end
    nvec++; if (rename_accept !== 2'b00) begin nerr++; $display("FAIL reset_accept got %b want 00", rename_accept); end
    nvec++; if (dispatch_valid !== 2'b00) begin nerr++; $display("FAIL reset_dvalid got %b want 00", dispatch_valid); end
    nvec++; if (dispatch_prd !== '0) begin nerr++; $display("FAIL reset_prd got %h want 0", dispatch_prd); end
    tick(); idle();
  endtask

  task automatic test_basic();
    logic [PW-1:0] ep[2], eo[2];
    idle(); set_lane(0, 1, 3, 3, 1, 0, 1); set_lane(1, 1, 3, 3, 2, 0, 1); i_ready = 1'b0; #1;
    nvec++; if (rename_accept !== 2'b00) begin nerr++; $display("FAIL no_ready_accept got %b want 00", rename_accept); end
    i_ready = 1'b1; #1;
    ep = '{7'd32, 7'd33}; eo = '{7'd1, 7'd2};
    nvec++; if (rename_accept !== 2'b11) begin nerr++; $display("FAIL basic_accept got %b want 11", rename_accept); end
    nvec++; if (dispatch_reg_write !== 2'b11) begin nerr++; $display("FAIL basic_regwr got %b want 11", dispatch_reg_write); end
    for (int l = 0; l < 2; l++) begin
      nvec++; if (g_prd(l) !== ep[l]) begin nerr++; $display("FAIL basic_prd%0d got %0d want %0d", l, g_prd(l), ep[l]); end
      nvec++; if (g_old(l) !== eo[l]) begin nerr++; $display("FAIL basic_old%0d got %0d want %0d", l, g_old(l), eo[l]); end
      nvec++; if (g_prs1(l) !== 7'd3 || g_prs2(l) !== 7'd3) begin nerr++;
        $display("FAIL basic_prs%0d got %0d/%0d want 3/3", l, g_prs1(l), g_prs2(l)); end
      nvec++; if (g_tag(l) !== RW'(l)) begin nerr++; $display("FAIL basic_tag%0d got %0d want %0d", l, g_tag(l), l); end
    end
    tick();
  endtask

  task automatic test_bypass();
    idle(); set_lane(0, 1, 1, 2, 5, 0, 1); set_lane(1, 1, 5, 0, 5, 0, 1); #1;
    nvec++; if (g_prs1(0) !== 7'd32 || g_prs2(0) !== 7'd33) begin nerr++;
      $display("FAIL byp_map_read got %0d/%0d want 32/33", g_prs1(0), g_prs2(0)); end
    nvec++; if (g_prd(0) !== 7'd34 || g_old(0) !== 7'd5) begin nerr++;
      $display("FAIL byp_lane0 got prd %0d old %0d want 34/5", g_prd(0), g_old(0)); end
    nvec++; if (g_prs1(1) !== 7'd34 || g_prs2(1) !== 7'd0) begin nerr++;
      $display("FAIL byp_prs_lane1 got %0d/%0d want 34/0", g_prs1(1), g_prs2(1)); end
    nvec++; if (g_old(1) !== 7'd34 || g_prd(1) !== 7'd35) begin nerr++;
      $display("FAIL byp_lane1 got old %0d prd %0d want 34/35", g_old(1), g_prd(1)); end
    nvec++; if (g_tag(0) !== 4'd2 || g_tag(1) !== 4'd3) begin nerr++;
      $display("FAIL byp_tags got %0d/%0d want 2/3", g_tag(0), g_tag(1)); end
    tick();
    // youngest writer of x5 must own the map entry; rd=x0 allocates nothing
    idle(); set_lane(0, 1, 5, 0, 0, 0, 1); #1;
    nvec++; if (rename_accept !== 2'b01) begin nerr++; $display("FAIL x0_accept got %b want 01", rename_accept); end
    nvec++; if (g_prs1(0) !== 7'd35) begin nerr++; $display("FAIL map_x5 got %0d want 35", g_prs1(0)); end
    nvec++; if (g_prd(0) !== 7'd0 || dispatch_reg_write !== 2'b00) begin nerr++;
      $display("FAIL x0_nowrite got prd %0d wr %b want 0/00", g_prd(0), dispatch_reg_write); end
    nvec++; if (g_tag(0) !== 4'd4) begin nerr++; $display("FAIL x0_tag got %0d want 4", g_tag(0)); end
    tick();
  endtask

  task automatic test_branch();
    idle(); set_lane(0, 1, 1, 2, 0, 1, 0); set_lane(1, 1, 5, 0, 4, 0, 1); #1;
    nvec++; if (rename_accept !== 2'b01) begin nerr++; $display("FAIL br_accept got %b want 01", rename_accept); end
    nvec++; if (dispatch_ckpt_id !== 2'd0 || dispatch_br_mask !== 4'b0000) begin nerr++;
      $display("FAIL br_ckpt got id %0d mask %b want 0/0000", dispatch_ckpt_id, dispatch_br_mask); end
    nvec++; if (g_tag(0) !== 4'd5) begin nerr++; $display("FAIL br_tag got %0d want 5", g_tag(0)); end
    tick();
    idle(); set_lane(0, 1, 5, 0, 4, 0, 1); #1;
    nvec++; if (rename_accept !== 2'b01) begin nerr++; $display("FAIL br_shift_accept got %b want 01", rename_accept); end
    nvec++; if (g_prd(0) !== 7'd36 || g_prs1(0) !== 7'd35 || g_old(0) !== 7'd4) begin nerr++;
      $display("FAIL br_shift_regs got %0d/%0d/%0d want 36/35/4", g_prd(0), g_prs1(0), g_old(0)); end
    nvec++; if (dispatch_br_mask !== 4'b0001 || g_tag(0) !== 4'd6) begin nerr++;
      $display("FAIL br_shift_mask got %b tag %0d want 0001/6", dispatch_br_mask, g_tag(0)); end
    tick();
  endtask

  task automatic test_mispredict();
    idle(); set_lane(0, 1, 0, 0, 0, 1, 0); #1;
    nvec++; if (dispatch_ckpt_id !== 2'd1 || dispatch_br_mask !== 4'b0001) begin nerr++;
      $display("FAIL mp_ckpt1 got id %0d mask %b want 1/0001", dispatch_ckpt_id, dispatch_br_mask); end
    tick();
    idle(); set_lane(0, 1, 0, 0, 1, 0, 1); set_lane(1, 1, 1, 0, 4, 0, 1); #1;
    nvec++; if (g_prd(0) !== 7'd37 || g_prd(1) !== 7'd38) begin nerr++;
      $display("FAIL mp_spec_prd got %0d/%0d want 37/38", g_prd(0), g_prd(1)); end
    nvec++; if (g_old(0) !== 7'd32 || g_old(1) !== 7'd36 || g_prs1(1) !== 7'd37) begin nerr++;
      $display("FAIL mp_spec_old got %0d/%0d prs %0d want 32/36/37", g_old(0), g_old(1), g_prs1(1)); end
    nvec++; if (dispatch_br_mask !== 4'b0011 || g_tag(0) !== 4'd8) begin nerr++;
      $display("FAIL mp_spec_mask got %b tag %0d want 0011/8", dispatch_br_mask, g_tag(0)); end
    tick();
    idle(); set_lane(0, 1, 0, 0, 6, 0, 1);
    branch_resolve = 1'b1; branch_mispredict = 1'b1; branch_ckpt_id = 2'd0;
    commit_en = 2'b11; commit_old_preg = {7'd2, 7'd1}; #1;
    nvec++; if (rename_ready !== 1'b0 || dispatch_valid !== 2'b00) begin nerr++;
      $display("FAIL mp_block got ready %0d dv %b want 0/00", rename_ready, dispatch_valid); end
    tick();
    idle(); set_lane(0, 1, 1, 4, 6, 0, 1); set_lane(1, 1, 5, 2, 7, 0, 1); #1;
    nvec++; if (g_prs1(0) !== 7'd32 || g_prs2(0) !== 7'd4 || g_prs1(1) !== 7'd35 || g_prs2(1) !== 7'd33) begin nerr++;
      $display("FAIL mp_map got %0d %0d %0d %0d want 32 4 35 33", g_prs1(0), g_prs2(0), g_prs1(1), g_prs2(1)); end
    nvec++; if (g_prd(0) !== 7'd36 || g_prd(1) !== 7'd37) begin nerr++;
      $display("FAIL mp_head got %0d/%0d want 36/37", g_prd(0), g_prd(1)); end
    nvec++; if (g_tag(0) !== 4'd6 || g_tag(1) !== 4'd7) begin nerr++;
      $display("FAIL mp_rob got %0d/%0d want 6/7", g_tag(0), g_tag(1)); end
    nvec++; if (dispatch_br_mask !== 4'b0000 || g_old(0) !== 7'd6) begin nerr++;
      $display("FAIL mp_freed got mask %b old %0d want 0000/6", dispatch_br_mask, g_old(0)); end
    tick();
  endtask

  task automatic test_resolve();
    idle(); set_lane(0, 1, 0, 0, 0, 1, 0); #1;
    nvec++; if (dispatch_ckpt_id !== 2'd0 || dispatch_br_mask !== 4'b0000 || g_tag(0) !== 4'd8) begin nerr++;
      $display("FAIL rs_alloc0 got id %0d mask %b tag %0d want 0/0000/8", dispatch_ckpt_id, dispatch_br_mask, g_tag(0)); end
    tick();
    idle(); set_lane(0, 1, 0, 0, 0, 1, 0); #1;
    nvec++; if (dispatch_ckpt_id !== 2'd1 || dispatch_br_mask !== 4'b0001 || g_tag(0) !== 4'd9) begin nerr++;
      $display("FAIL rs_alloc1 got id %0d mask %b tag %0d want 1/0001/9", dispatch_ckpt_id, dispatch_br_mask, g_tag(0)); end
    tick();
    idle(); set_lane(0, 1, 0, 0, 1, 0, 1); #1;
    nvec++; if (g_prd(0) !== 7'd38 || g_old(0) !== 7'd32 || dispatch_br_mask !== 4'b0011) begin nerr++;
      $display("FAIL rs_spec got prd %0d old %0d mask %b want 38/32/0011", g_prd(0), g_old(0), dispatch_br_mask); end
    tick();
    idle(); branch_resolve = 1'b1; branch_ckpt_id = 2'd0; tick();
    idle(); set_lane(0, 1, 1, 0, 3, 0, 1); #1;
    nvec++; if (dispatch_br_mask !== 4'b0010) begin nerr++; $display("FAIL rs_correct_mask got %b want 0010", dispatch_br_mask); end
    nvec++; if (g_prs1(0) !== 7'd38 || g_prd(0) !== 7'd39 || g_tag(0) !== 4'd11) begin nerr++;
      $display("FAIL rs_after_ok got prs %0d prd %0d tag %0d want 38/39/11", g_prs1(0), g_prd(0), g_tag(0)); end
    tick();
    idle(); set_lane(0, 1, 0, 0, 9, 0, 1);
    branch_resolve = 1'b1; branch_mispredict = 1'b1; branch_ckpt_id = 2'd1; #1;
    nvec++; if (dispatch_valid !== 2'b00) begin nerr++; $display("FAIL rs_mp_block got %b want 00", dispatch_valid); end
    tick();
    idle(); set_lane(0, 1, 1, 3, 2, 0, 1); #1;
    nvec++; if (g_prs1(0) !== 7'd32 || g_prs2(0) !== 7'd3 || g_old(0) !== 7'd33) begin nerr++;
      $display("FAIL rs_mp_map got %0d/%0d old %0d want 32/3/33", g_prs1(0), g_prs2(0), g_old(0)); end
    nvec++; if (g_prd(0) !== 7'd38 || g_tag(0) !== 4'd10 || dispatch_br_mask !== 4'b0000) begin nerr++;
      $display("FAIL rs_mp_state got prd %0d tag %0d mask %b want 38/10/0000", g_prd(0), g_tag(0), dispatch_br_mask); end
    tick();
    idle(); branch_resolve = 1'b1; branch_mispredict = 1'b1; branch_ckpt_id = 2'd1; tick();
    idle(); set_lane(0, 1, 2, 0, 8, 0, 1); #1;
    nvec++; if (g_prs1(0) !== 7'd38 || g_prd(0) !== 7'd39 || g_tag(0) !== 4'd11) begin nerr++;
      $display("FAIL rs_stale_id got prs %0d prd %0d tag %0d want 38/39/11", g_prs1(0), g_prd(0), g_tag(0)); end
    tick();
  endtask

  task automatic test_back_to_back();
    int e;
    logic [PW-1:0] ep[2];
    // head 8, tail 98: 45 full groups drain the list, ending on the pregs pushed during the mispredict
    for (int n = 0; n < 45; n++) begin
      idle(); set_lane(0, 1, 0, 0, 10, 0, 1); set_lane(1, 1, 0, 0, 11, 0, 1); #1;
      for (int l = 0; l < 2; l++) begin
        e = 8 + 2*n + l;
        ep[l] = (e < 96) ? PW'(32 + e) : PW'(e - 95);
      end
      nvec++; if (rename_accept !== 2'b11 || g_prd(0) !== ep[0] || g_prd(1) !== ep[1]) begin nerr++;
        $display("FAIL b2b_%0d got acc %b prd %0d/%0d want 11 %0d/%0d", n, rename_accept, g_prd(0), g_prd(1), ep[0], ep[1]); end
      tick();
    end
    idle(); set_lane(0, 1, 0, 0, 10, 0, 1); #1;
    nvec++; if (rename_ready !== 1'b0 || rename_accept !== 2'b00) begin nerr++;
      $display("FAIL empty_block got ready %0d acc %b want 0/00", rename_ready, rename_accept); end
    set_lane(0, 1, 0, 0, 0, 0, 1); set_lane(1, 1, 0, 0, 9, 0, 0); #1;
    nvec++; if (rename_accept !== 2'b11 || dispatch_reg_write !== 2'b00) begin nerr++;
      $display("FAIL empty_nowrite got acc %b wr %b want 11/00", rename_accept, dispatch_reg_write); end
    tick();
    idle(); set_lane(0, 1, 0, 0, 10, 0, 1); commit_en = 2'b01; commit_old_preg = {7'd0, 7'd40}; #1;
    nvec++; if (rename_ready !== 1'b0) begin nerr++; $display("FAIL free_same_cycle got %0d want 0", rename_ready); end
    tick();
    idle(); set_lane(0, 1, 0, 0, 10, 0, 1); #1;
    nvec++; if (rename_accept !== 2'b01 || g_prd(0) !== 7'd40) begin nerr++;
      $display("FAIL free_reuse got acc %b prd %0d want 01/40", rename_accept, g_prd(0)); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nvec = 0; nerr = 0;
    idle(); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_basic();
    test_bypass();
    test_branch();
    test_mispredict();
    test_resolve();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
